// File: rtl/seven_seg_capture.sv
// Snoops a time-multiplexed, active-low 7-segment bus and recovers the hex value shown
// on each digit, with per-digit validity timeout, blank/illegal flags and a frame pulse.
module seven_seg_capture #(
  parameter int NUM_DIGITS     = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [NUM_DIGITS-1:0]   illegal,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [6:0]              seg_s1, seg_s2, lat_pat;
  logic [NUM_DIGITS-1:0]   an_s1, an_s2, low, cap_mask, seen, seen_nxt;
  logic [IW-1:0]           cur_idx, lat_idx;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           tcnt [NUM_DIGITS];
  logic                    one_low, same, latch_en, count_en, capture;
  logic [4:0]              dec;

  // {hit, value}; hit is 0 for any pattern outside the hex table
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = {1'b1, 4'h0};
      7'b1001111: decode = {1'b1, 4'h1};
      7'b0010010: decode = {1'b1, 4'h2};
      7'b0000110: decode = {1'b1, 4'h3};
      7'b1001100: decode = {1'b1, 4'h4};
      7'b0100100: decode = {1'b1, 4'h5};
      7'b0100000: decode = {1'b1, 4'h6};
      7'b0001111: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0000100: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b1100000: decode = {1'b1, 4'hB};
      7'b0110001: decode = {1'b1, 4'hC};
      7'b1000010: decode = {1'b1, 4'hD};
      7'b0110000: decode = {1'b1, 4'hE};
      7'b0111000: decode = {1'b1, 4'hF};
      default:    decode = 5'b0;
    endcase
  endfunction

  // Synchronisers idle at all-ones so reset looks like "no digit selected"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      an_s1  <= '1;
      an_s2  <= '1;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      an_s1  <= an_in;
      an_s2  <= an_s1;
    end
  end

  always_comb begin
    low     = ~an_s2;
    one_low = (low != '0) && ((low & (low - NUM_DIGITS'(1))) == '0);
    cur_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (low[i]) cur_idx = IW'(i);
    same = one_low && (cur_idx == lat_idx) && (seg_s2 == lat_pat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (one_low) state_nxt = (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;
      SETTLE:  if (!same) state_nxt = IDLE;
               else if (cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (!same) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    latch_en = (state == IDLE) && one_low;
    count_en = (state == SETTLE) && same;
    capture  = (state == CAPTURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_idx <= '0;
      lat_pat <= '0;
      cnt     <= '0;
    end else if (latch_en) begin
      lat_idx <= cur_idx;
      lat_pat <= seg_s2;
      cnt     <= CW'(1);
    end else if (count_en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign dec = decode(lat_pat);

  always_comb begin
    cap_mask = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      cap_mask[k] = capture && (lat_idx == IW'(k));
  end

  assign seen_nxt = seen | cap_mask;

  // A capture takes priority over the saturating timeout of the same digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      digit_blank <= '0;
      illegal     <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) tcnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_mask[k]) begin
          if (dec[4]) begin
            digits[4*k +: 4] <= dec[3:0];
            illegal[k]       <= 1'b0;
            digit_blank[k]   <= 1'b0;
          end else if (lat_pat == 7'b1111111) begin
            digit_blank[k] <= 1'b1;
            illegal[k]     <= 1'b0;
          end else begin
            illegal[k]     <= 1'b1;
            digit_blank[k] <= 1'b0;
          end
          digit_valid[k] <= 1'b1;
          tcnt[k]        <= '0;
        end else if (tcnt[k] != TW'(TIMEOUT_CYCLES)) begin
          tcnt[k] <= tcnt[k] + TW'(1);
          if (tcnt[k] == TW'(TIMEOUT_CYCLES - 1)) digit_valid[k] <= 1'b0;
        end
      end
      frame_done <= &seen_nxt;
      seen       <= (&seen_nxt) ? '0 : seen_nxt;
    end
  end

endmodule
